// File: rtl/incr_pkg.sv
// Shared types and defaults for the incrementer-driven counter block.
package incr_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/incr_ref_check.sv
// Flags when an external incrementer result differs from a + 1.
module incr_ref_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output logic             mismatch
);

  logic [WIDTH:0] expected;

  assign expected = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
  assign mismatch = ({cout, s} != expected);

endmodule

// File: rtl/incr_count_reg.sv
// Counter whose increment is performed by an external incrementer; this block
// sequences IDLE/RUN/DONE, hands cnt_q to a ready/valid consumer, and audits the sums.
module incr_count_reg
  import incr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic [WIDTH-1:0] inc_s,
  input  logic             inc_cout,
  output logic [WIDTH-1:0] inc_a,
  output logic             inc_high,
  output logic [WIDTH-1:0] cnt_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt, err_nxt;
  logic             xfer;
  logic             mismatch;

  // Value taken on a carry-out: wrap to zero or pin at all-ones.
  function automatic logic [WIDTH-1:0] carry_count();
    return WRAP ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
  endfunction

  incr_ref_check #(.WIDTH(WIDTH)) u_ref_check (
    .a        (cnt_q),
    .s        (inc_s),
    .cout     (inc_cout),
    .mismatch (mismatch)
  );

  assign inc_a     = cnt_q;
  assign out_valid = (state == RUN);
  assign done      = (state == DONE);
  assign xfer      = (state == RUN) && out_ready && !stop;
  assign inc_high  = xfer;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    ovf_nxt   = ovf;
    err_nxt   = err;
    unique case (state)
      IDLE: begin
        if (load) cnt_nxt = load_val;
        if (start) begin
          state_nxt = RUN;
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          if (inc_cout) ovf_nxt = 1'b1;
          if (mismatch) err_nxt = 1'b1;
          // A saturating carry ends the run even if the terminal count also matches.
          if (inc_cout && !WRAP) begin
            cnt_nxt   = carry_count();
            state_nxt = DONE;
          end else if (cnt_q == term_val) begin
            cnt_nxt   = inc_s;
            state_nxt = DONE;
          end else if (inc_cout) begin
            cnt_nxt = carry_count();
          end else begin
            cnt_nxt = inc_s;
          end
        end
      end
      DONE: begin
        if (load) cnt_nxt = load_val;
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = RUN;
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and count register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      ovf   <= ovf_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_incr_count_reg.sv
// Self-checking bench: a wrapping and a saturating counter share stimulus and
// are checked against directed expectations and an arithmetic reference model.
module tb_incr_count_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst_n, start, stop, load, out_ready, fault;
  logic [W-1:0] load_val, term_val;

  logic [W-1:0] inc_a_w, inc_s_w, cnt_w;
  logic         inc_high_w, inc_cout_w, vld_w, done_w, ovf_w, err_w;
  logic [W-1:0] inc_a_s, inc_s_s, cnt_s;
  logic         inc_high_s, inc_cout_s, vld_s, done_s, ovf_s, err_s;

  int checks = 0;
  int failures = 0;

  // Reference model state: index 0 = wrapping instance, 1 = saturating instance.
  // m_st: 0 idle, 1 run, 2 done.
  int           m_st[2];
  logic [W-1:0] m_cnt[2];
  bit           m_ovf[2];
  bit           m_err[2];

  // External incrementer: sum = a + carry-in, or a broken one echoing a.
  assign {inc_cout_w, inc_s_w} = fault ? {1'b0, inc_a_w} : {1'b0, inc_a_w} + {{W{1'b0}}, inc_high_w};
  assign {inc_cout_s, inc_s_s} = fault ? {1'b0, inc_a_s} : {1'b0, inc_a_s} + {{W{1'b0}}, inc_high_s};

  incr_count_reg #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .term_val(term_val), .inc_s(inc_s_w), .inc_cout(inc_cout_w),
    .inc_a(inc_a_w), .inc_high(inc_high_w), .cnt_q(cnt_w), .out_valid(vld_w),
    .out_ready(out_ready), .done(done_w), .ovf(ovf_w), .err(err_w)
  );

  incr_count_reg #(.WIDTH(W), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .term_val(term_val), .inc_s(inc_s_s), .inc_cout(inc_cout_s),
    .inc_a(inc_a_s), .inc_high(inc_high_s), .cnt_q(cnt_s), .out_valid(vld_s),
    .out_ready(out_ready), .done(done_s), .ovf(ovf_s), .err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    int sum, expect_sum;
    bit carry;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_cnt[i] = '0; m_ovf[i] = 0; m_err[i] = 0;
      end else begin
        case (m_st[i])
          0: begin
            if (load) m_cnt[i] = load_val;
            if (start) begin m_st[i] = 1; m_ovf[i] = 0; m_err[i] = 0; end
          end
          1: begin
            if (stop) m_st[i] = 0;
            else if (out_ready) begin
              expect_sum = int'(m_cnt[i]) + 1;
              sum = fault ? int'(m_cnt[i]) : expect_sum;
              carry = (sum >= (1 << W));
              if (sum != expect_sum) m_err[i] = 1;
              if (carry) m_ovf[i] = 1;
              if (carry && i == 1) begin
                m_cnt[i] = '1; m_st[i] = 2;
              end else if (m_cnt[i] == term_val) begin
                m_cnt[i] = W'(sum % (1 << W)); m_st[i] = 2;
              end else if (carry) begin
                m_cnt[i] = '0;
              end else begin
                m_cnt[i] = W'(sum);
              end
            end
          end
          default: begin
            if (load) m_cnt[i] = load_val;
            if (stop) m_st[i] = 0;
            else if (start) begin m_st[i] = 1; m_ovf[i] = 0; m_err[i] = 0; end
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic ld,
                       input logic [W-1:0] lv, input logic [W-1:0] tv, input logic rdy);
    start = st; stop = sp; load = ld; load_val = lv; term_val = tv; out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fault = 1'b0;
    drive(0, 0, 0, '0, '0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fault = 1'b0;
    drive(1, 0, 1, 4'd7, 4'd3, 1);
    tick();
    checks++;
    if (cnt_w !== 4'd0 || cnt_s !== 4'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%h/%h want=0/0", cnt_w, cnt_s);
    end
    checks++;
    if ({vld_w, done_w, ovf_w, err_w, inc_high_w, vld_s, done_s, ovf_s, err_s, inc_high_s} !== 10'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0", {vld_w, done_w, ovf_w, err_w, inc_high_w, vld_s, done_s, ovf_s, err_s, inc_high_s});
    end
    rst_n = 1'b1;
    drive(0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_count();
    int expv;
    do_reset();
    drive(1, 0, 1, 4'd3, 4'd6, 1);
    tick();
    drive(0, 0, 0, 4'd0, 4'd6, 1);
    checks++;
    if (cnt_w !== 4'd3 || inc_a_w !== 4'd3 || vld_w !== 1'b1 || inc_high_w !== 1'b1) begin
      failures++;
      $display("FAIL count_load got cnt=%h a=%h v=%b hi=%b want 3 3 1 1", cnt_w, inc_a_w, vld_w, inc_high_w);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      expv = 4 + k;
      checks++;
      if (cnt_w !== W'(expv) || cnt_s !== W'(expv)) begin
        failures++;
        $display("FAIL count_step%0d got=%h/%h want=%h", k, cnt_w, cnt_s, expv);
      end
    end
    checks++;
    if (done_w !== 1'b1 || ovf_w !== 1'b0 || vld_w !== 1'b0 || cnt_w !== 4'd7) begin
      failures++;
      $display("FAIL count_done got done=%b ovf=%b v=%b cnt=%h want 1 0 0 7", done_w, ovf_w, vld_w, cnt_w);
    end
  endtask

  task automatic test_wrap();
    int exp_w[5];
    exp_w = '{15, 0, 1, 2, 3};
    do_reset();
    drive(1, 0, 1, 4'd14, 4'd2, 1);
    tick();
    drive(0, 0, 0, 4'd0, 4'd2, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (cnt_w !== W'(exp_w[k]) || done_w !== (k == 4)) begin
        failures++;
        $display("FAIL wrap_step%0d got cnt=%h done=%b want cnt=%h done=%b", k, cnt_w, done_w, exp_w[k], (k == 4));
      end
      if (k == 1) begin
        checks++;
        if (ovf_w !== 1'b1) begin
          failures++;
          $display("FAIL wrap_ovf got=%b want=1", ovf_w);
        end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 0, 1, 4'd14, 4'd9, 1);
    tick();
    drive(0, 0, 0, 4'd0, 4'd9, 1);
    tick();
    checks++;
    if (cnt_s !== 4'd15 || done_s !== 1'b0 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_first got cnt=%h done=%b ovf=%b want f 0 0", cnt_s, done_s, ovf_s);
    end
    tick();
    checks++;
    if (cnt_s !== 4'd15 || done_s !== 1'b1 || ovf_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_carry got cnt=%h done=%b ovf=%b want f 1 1", cnt_s, done_s, ovf_s);
    end
    tick();
    checks++;
    if (cnt_s !== 4'd15 || done_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold got cnt=%h done=%b want f 1", cnt_s, done_s);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 0, 1, 4'd5, 4'd12, 0);
    tick();
    drive(0, 0, 0, 4'd0, 4'd12, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cnt_w !== 4'd5 || inc_high_w !== 1'b0 || vld_w !== 1'b1) begin
        failures++;
        $display("FAIL stall%0d got cnt=%h hi=%b v=%b want 5 0 1", k, cnt_w, inc_high_w, vld_w);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (inc_high_w !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_hi got=%b want=1", inc_high_w);
    end
    tick();
    checks++;
    if (cnt_w !== 4'd6) begin
      failures++;
      $display("FAIL stall_release got=%h want=6", cnt_w);
    end
  endtask

  task automatic test_err();
    do_reset();
    fault = 1'b1;
    drive(1, 0, 1, 4'd2, 4'd12, 1);
    tick();
    drive(0, 0, 0, 4'd0, 4'd12, 1);
    tick();
    checks++;
    if (err_w !== 1'b1 || err_s !== 1'b1 || cnt_w !== 4'd2) begin
      failures++;
      $display("FAIL err_set got err=%b/%b cnt=%h want 1/1 2", err_w, err_s, cnt_w);
    end
    fault = 1'b0;
    tick();
    tick();
    checks++;
    if (err_w !== 1'b1 || cnt_w !== 4'd4) begin
      failures++;
      $display("FAIL err_sticky got err=%b cnt=%h want 1 4", err_w, cnt_w);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (err_w !== 1'b1 || vld_w !== 1'b0 || cnt_w !== 4'd4) begin
      failures++;
      $display("FAIL err_idle got err=%b v=%b cnt=%h want 1 0 4", err_w, vld_w, cnt_w);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err_w !== 1'b0 || vld_w !== 1'b1) begin
      failures++;
      $display("FAIL err_clear got err=%b v=%b want 0 1", err_w, vld_w);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    drive(1, 0, 1, 4'd8, 4'd14, 1);
    tick();
    drive(0, 0, 0, 4'd0, 4'd14, 1);
    tick();
    checks++;
    if (cnt_w !== 4'd9 || vld_w !== 1'b1) begin
      failures++;
      $display("FAIL midrun_setup got cnt=%h v=%b want 9 1", cnt_w, vld_w);
    end
    rst_n = 1'b0;
    stop = 1'b1;
    tick();
    checks++;
    if (cnt_w !== 4'd0 || {vld_w, done_w, ovf_w, err_w, inc_high_w} !== 5'b0) begin
      failures++;
      $display("FAIL midrun_reset got cnt=%h flags=%b want 0 00000", cnt_w, {vld_w, done_w, ovf_w, err_w, inc_high_w});
    end
    rst_n = 1'b1;
    stop = 1'b0;
  endtask

  task automatic test_random();
    logic [4*W+5:0] got, want;
    bit hi;
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      fault = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
      #1;
      for (int i = 0; i < 2; i++) begin
        hi = (m_st[i] == 1) && out_ready && !stop;
        want = {m_cnt[i], m_cnt[i], (m_st[i] == 1), (m_st[i] == 2), m_ovf[i], m_err[i], hi, 1'b0};
        if (i == 0) got = {cnt_w, inc_a_w, vld_w, done_w, ovf_w, err_w, inc_high_w, 1'b0};
        else        got = {cnt_s, inc_a_s, vld_s, done_s, ovf_s, err_s, inc_high_s, 1'b0};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL random_inst%0d_cyc%0d got=%h want=%h", i, n, got, want);
        end
      end
      tick();
    end
    rst_n = 1'b1;
    fault = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fault = 1'b0;
    drive(0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = '0; m_ovf[i] = 0; m_err[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_count();
    test_wrap();
    test_saturate();
    test_stall();
    test_err();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
